// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash responder: decodes READ + 24-bit address, streams words fetched over a req/rvalid
// port back on MISO. All SPI pins are oversampled on the system clock.
module spi_flash_responder #(
    parameter logic [7:0]  CMD_READ    = 8'h03,
    parameter int unsigned ADDR_BITS   = 24,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 sck,
    input  logic                 ss_n,
    input  logic                 mosi,
    output logic                 miso,
    output logic                 mem_req,
    output logic [ADDR_BITS-1:0] mem_addr,
    input  logic [31:0]          mem_rdata,
    input  logic                 mem_rvalid,
    output logic                 busy,
    output logic                 err_cmd,
    output logic                 err_late
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StCmd    = 3'd1;
    localparam logic [2:0] StAddr   = 3'd2;
    localparam logic [2:0] StIgnore = 3'd3;
    localparam logic [2:0] StData   = 3'd4;

    logic [SYNC_STAGES-1:0] sck_sync, ss_sync, mosi_sync;
    logic                   sck_prev, ss_prev;
    logic                   sck_s, ss_s, mosi_s;
    logic                   sck_rise, sck_fall, ss_rise, ss_fall;

    logic [2:0]           state_q;
    logic [7:0]           bit_cnt_q;
    logic [6:0]           cmd_sh_q;
    logic [ADDR_BITS-2:0] addr_sh_q;
    logic [31:0]          tx_sh_q;
    logic [31:0]          buf_q;
    logic                 buf_valid_q;
    logic                 stale_q;    // outstanding fetch belongs to a word already sent as zeros
    logic                 reissue_q;

    logic                 rv;
    logic [7:0]           cmd_full;
    logic [ADDR_BITS-1:0] addr_full;
    logic [31:0]          tx_word;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sck_sync  <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
        end
    end

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign ss_s     = ss_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign ss_fall  = ss_prev & ~ss_s;
    assign ss_rise  = ~ss_prev & ss_s;
    assign sck_rise = ~ss_s & ~sck_prev & sck_s;
    assign sck_fall = ~ss_s & sck_prev & ~sck_s;
    assign busy     = ~ss_s;

    assign rv        = mem_req & mem_rvalid;
    assign cmd_full  = {cmd_sh_q, mosi_s};
    assign addr_full = {addr_sh_q, mosi_s};
    // Reorder so a plain MSB-first shift yields bytes in ascending address order.
    assign tx_word   = {buf_q[7:0], buf_q[15:8], buf_q[23:16], buf_q[31:24]};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sck_prev    <= 1'b0;
            ss_prev     <= 1'b1;
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            cmd_sh_q    <= '0;
            addr_sh_q   <= '0;
            tx_sh_q     <= '0;
            buf_q       <= '0;
            buf_valid_q <= 1'b0;
            stale_q     <= 1'b0;
            reissue_q   <= 1'b0;
            miso        <= 1'b0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            err_cmd     <= 1'b0;
            err_late    <= 1'b0;
        end else begin
            sck_prev <= sck_s;
            ss_prev  <= ss_s;
            if (ss_rise) begin
                state_q     <= StIdle;
                miso        <= 1'b0;
                mem_req     <= 1'b0;
                buf_valid_q <= 1'b0;
                stale_q     <= 1'b0;
                reissue_q   <= 1'b0;
            end else if (ss_fall) begin
                state_q   <= StCmd;
                bit_cnt_q <= '0;
                cmd_sh_q  <= '0;
                addr_sh_q <= '0;
                tx_sh_q   <= '0;
                miso      <= 1'b0;
                err_cmd   <= 1'b0;
                err_late  <= 1'b0;
            end else begin
                if (rv) begin
                    mem_req <= 1'b0;
                    if (stale_q) begin
                        stale_q   <= 1'b0;
                        reissue_q <= 1'b1;
                    end else begin
                        buf_q       <= mem_rdata;
                        buf_valid_q <= 1'b1;
                    end
                end
                if (reissue_q) begin
                    reissue_q <= 1'b0;
                    mem_req   <= 1'b1;
                    mem_addr  <= mem_addr + ADDR_BITS'(4);
                end
                case (state_q)
                    StCmd: if (sck_rise) begin
                        cmd_sh_q  <= cmd_full[6:0];
                        bit_cnt_q <= bit_cnt_q + 8'd1;
                        if (bit_cnt_q == 8'd7) begin
                            bit_cnt_q <= '0;
                            if (cmd_full == CMD_READ) begin
                                state_q <= StAddr;
                            end else begin
                                state_q <= StIgnore;
                                err_cmd <= 1'b1;
                            end
                        end
                    end
                    StAddr: if (sck_rise) begin
                        addr_sh_q <= addr_full[ADDR_BITS-2:0];
                        bit_cnt_q <= bit_cnt_q + 8'd1;
                        if (bit_cnt_q == 8'(ADDR_BITS - 1)) begin
                            bit_cnt_q <= '0;
                            mem_addr  <= addr_full & ~ADDR_BITS'(3);
                            mem_req   <= 1'b1;
                            state_q   <= StData;
                        end
                    end
                    StData: if (sck_fall) begin
                        bit_cnt_q <= bit_cnt_q + 8'd1;
                        if (bit_cnt_q[4:0] == 5'd0) begin
                            if (buf_valid_q) begin
                                miso        <= tx_word[31];
                                tx_sh_q     <= {tx_word[30:0], 1'b0};
                                buf_valid_q <= 1'b0;
                                mem_req     <= 1'b1;
                                mem_addr    <= mem_addr + ADDR_BITS'(4);
                            end else begin
                                // Word missed: send zeros, let the late fetch drain, then advance.
                                miso     <= 1'b0;
                                tx_sh_q  <= '0;
                                err_late <= 1'b1;
                                if (rv) begin
                                    buf_valid_q <= 1'b0;
                                    reissue_q   <= 1'b1;
                                end else begin
                                    stale_q <= 1'b1;
                                end
                            end
                        end else begin
                            miso    <= tx_sh_q[31];
                            tx_sh_q <= {tx_sh_q[30:0], 1'b0};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: table of READ transfers against a latency-controlled
// memory model, plus abort, late-data and reset sequences.
module tb_spi_flash_responder;

    localparam int H = 5;  // sck half period in system clocks

    logic        clock = 1'b0;
    logic        reset;
    logic        sck;
    logic        ss_n;
    logic        mosi;
    logic        miso;
    logic        mem_req;
    logic [23:0] mem_addr;
    logic [31:0] mem_rdata = '0;
    logic        mem_rvalid = 1'b0;
    logic        busy;
    logic        err_cmd;
    logic        err_late;

    always #5 clock = ~clock;

    spi_flash_responder dut (
        .clock      (clock),
        .reset      (reset),
        .sck        (sck),
        .ss_n       (ss_n),
        .mosi       (mosi),
        .miso       (miso),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .busy       (busy),
        .err_cmd    (err_cmd),
        .err_late   (err_late)
    );

    function automatic logic [31:0] lookup(input logic [23:0] a);
        if (a == 24'h000010) return 32'h44332211;
        if (a == 24'h000014) return 32'h88776655;
        return {16'hC0DE, a[15:0]};
    endfunction

    // Memory model: answers each request after lat cycles; logs every request start.
    int          lat = 1;
    int          wcnt = 0;
    logic        req_prev = 1'b0;
    logic [23:0] reqs [64];
    int          nreq = 0;

    always @(posedge clock) begin
        mem_rvalid <= 1'b0;
        if (mem_req && !mem_rvalid) begin
            if (wcnt >= lat) begin
                mem_rvalid <= 1'b1;
                mem_rdata  <= lookup(mem_addr);
                wcnt       <= 0;
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            wcnt <= 0;
        end
        req_prev <= mem_req;
        if (mem_req && !req_prev) begin
            if (nreq < 64) reqs[nreq] <= mem_addr;
            nreq <= nreq + 1;
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic half();
        repeat (H) @(negedge clock);
    endtask

    task automatic start();
        @(negedge clock);
        ss_n = 1'b0;
        repeat (6) @(negedge clock);
    endtask

    task automatic stop();
        ss_n = 1'b1;
        repeat (4) @(negedge clock);
        sck  = 1'b0;
        mosi = 1'b0;
        repeat (8) @(negedge clock);
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            mosi = v[i];
            half();
            sck = 1'b1;
            half();
            sck = 1'b0;
        end
    endtask

    // Samples miso at each rise; the final fall is withheld so no extra word boundary occurs.
    task automatic recv(input int nw, output logic [63:0] rx);
        rx = '0;
        for (int k = 0; k < nw * 32; k++) begin
            half();
            rx[(k / 32) * 32 + ((k % 32) / 8) * 8 + 7 - (k % 8)] = miso;
            sck = 1'b1;
            half();
            if (k != nw * 32 - 1) sck = 1'b0;
        end
        half();
    endtask

    typedef struct {
        logic [7:0]  cmd;
        logic [23:0] addr;
        int          nw;
        int          lat;
        logic [63:0] exp_rx;
        int          exp_nreq;
        logic [23:0] r0;
        logic [23:0] r1;
        logic        ecmd;
        logic        elate;
    } vec_t;

    vec_t        vecs [7];
    logic [63:0] rx;
    int          b;

    initial begin
        vecs[0] = '{8'h03, 24'h000010, 1, 1,  {32'h0, 32'h44332211}, 2,
                    24'h000010, 24'h000014, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 24'h000010, 2, 1,  {32'h88776655, 32'h44332211}, 3,
                    24'h000010, 24'h000014, 1'b0, 1'b0};
        vecs[2] = '{8'h9F, 24'h000010, 1, 1,  64'h0, 0,
                    24'h0, 24'h0, 1'b1, 1'b0};
        vecs[3] = '{8'h03, 24'h000010, 1, 1,  {32'h0, 32'h44332211}, 2,
                    24'h000010, 24'h000014, 1'b0, 1'b0};
        vecs[4] = '{8'h03, 24'hFFFFFE, 2, 1,  {32'hC0DE0000, 32'hC0DEFFFC}, 3,
                    24'hFFFFFC, 24'h000000, 1'b0, 1'b0};
        vecs[5] = '{8'h03, 24'h000010, 2, 30, {32'h88776655, 32'h0}, 3,
                    24'h000010, 24'h000014, 1'b0, 1'b1};
        vecs[6] = '{8'h03, 24'h000014, 1, 1,  {32'h0, 32'h88776655}, 2,
                    24'h000014, 24'h000018, 1'b0, 1'b0};

        reset = 1'b1;
        sck   = 1'b0;
        ss_n  = 1'b1;
        mosi  = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_miso", 64'(miso), 64'(0));
        check("reset_mem_req", 64'(mem_req), 64'(0));
        check("reset_mem_addr", 64'(mem_addr), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_err_cmd", 64'(err_cmd), 64'(0));
        check("reset_err_late", 64'(err_late), 64'(0));
        reset = 1'b0;
        repeat (3) @(negedge clock);

        for (int v = 0; v < 7; v++) begin
            lat = vecs[v].lat;
            b = nreq;
            start();
            send_bits({24'h0, vecs[v].cmd}, 8);
            send_bits({8'h0, vecs[v].addr}, 24);
            recv(vecs[v].nw, rx);
            check($sformatf("v%0d_data", v), rx, vecs[v].exp_rx);
            check($sformatf("v%0d_busy", v), 64'(busy), 64'(1));
            check($sformatf("v%0d_err_cmd", v), 64'(err_cmd), 64'(vecs[v].ecmd));
            check($sformatf("v%0d_err_late", v), 64'(err_late), 64'(vecs[v].elate));
            stop();
            check($sformatf("v%0d_nreq", v), 64'(nreq - b), 64'(vecs[v].exp_nreq));
            if (vecs[v].exp_nreq > 0)
                check($sformatf("v%0d_req0", v), 64'(reqs[b]), 64'(vecs[v].r0));
            if (vecs[v].exp_nreq > 1)
                check($sformatf("v%0d_req1", v), 64'(reqs[b + 1]), 64'(vecs[v].r1));
            check($sformatf("v%0d_idle_busy", v), 64'(busy), 64'(0));
            check($sformatf("v%0d_idle_miso", v), 64'(miso), 64'(0));
            check($sformatf("v%0d_idle_req", v), 64'(mem_req), 64'(0));
        end
        lat = 1;

        // Abort after 20 address bits: no request, back to idle.
        b = nreq;
        start();
        send_bits(32'h03, 8);
        send_bits(32'h00001, 20);
        stop();
        check("abort_nreq", 64'(nreq - b), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_miso", 64'(miso), 64'(0));

        // err_late stays set while idle and clears on the next ss_n fall.
        lat = 30;
        start();
        send_bits(32'h03, 8);
        send_bits(32'h10, 24);
        recv(1, rx);
        check("late_word0", rx, 64'h0);
        stop();
        check("late_sticky", 64'(err_late), 64'(1));
        lat = 1;
        start();
        check("late_cleared", 64'(err_late), 64'(0));
        check("late_busy", 64'(busy), 64'(1));
        stop();

        // Reset pulsed in the middle of the data phase.
        start();
        send_bits(32'h03, 8);
        send_bits(32'h10, 24);
        for (int k = 0; k < 8; k++) begin
            half();
            sck = 1'b1;
            half();
            sck = 1'b0;
        end
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("rst_mid_miso", 64'(miso), 64'(0));
        check("rst_mid_mem_req", 64'(mem_req), 64'(0));
        check("rst_mid_mem_addr", 64'(mem_addr), 64'(0));
        check("rst_mid_busy", 64'(busy), 64'(0));
        check("rst_mid_err_cmd", 64'(err_cmd), 64'(0));
        check("rst_mid_err_late", 64'(err_late), 64'(0));
        ss_n = 1'b1;
        repeat (5) @(negedge clock);
        reset = 1'b0;
        b = nreq;
        repeat (20) @(negedge clock);
        check("rst_after_nreq", 64'(nreq - b), 64'(0));
        check("rst_after_req", 64'(mem_req), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
